snoop_bus_arbiter: RTL and testbench

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter_if.sv | 33 +++
 rtl/snoop_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the snooped cache and the snoop arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and snooped cache's view.
interface snoop_bus_arbiter_if;
    logic        ooo_req;
    logic        ppl_req;
    logic [31:0] ooo_addr;
    logic [31:0] ppl_addr;
    logic [2:0]  ooo_cmd;
    logic [2:0]  ppl_cmd;
    logic        snoop_ack;
    logic        snoop_hit;
    logic        ooo_gnt;
    logic        ppl_gnt;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic [2:0]  snoop_cmd;
    logic        snoop_target;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic        bus_busy;

    modport slave (
        input  ooo_req, ppl_req, ooo_addr, ppl_addr, ooo_cmd, ppl_cmd, snoop_ack, snoop_hit,
        output ooo_gnt, ppl_gnt, snoop_valid, snoop_addr, snoop_cmd, snoop_target,
               resp_valid, resp_code, bus_busy
    );

    modport master (
        output ooo_req, ppl_req, ooo_addr, ppl_addr, ooo_cmd, ppl_cmd, snoop_ack, snoop_hit,
        input  ooo_gnt, ppl_gnt, snoop_valid, snoop_addr, snoop_cmd, snoop_target,
               resp_valid, resp_code, bus_busy
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Two-requester snoop arbiter with a timeout on the snooped cache's acknowledge.
// Define SNOOP_ARB_RR_EN for round-robin tie breaking; the default is fixed priority to ooo.
//
// state   | meaning
// IDLE    | waiting for a request; latches winner, address and command
// SNOOP   | broadcast to the non-owner cache, counting cycles until ack or timeout
// RESP    | one-cycle completion pulse with the latched response code
module snoop_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    snoop_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        owner_q;        // 0 = ooo, 1 = ppl
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [2:0]  cmd_q;
    logic        ooo_gnt_q;
    logic        ppl_gnt_q;
    logic        snoop_valid_q;
    logic        snoop_target_q;
    logic        resp_valid_q;
    logic [1:0]  resp_code_q;
    logic        busy_q;
    logic        win_d;

`ifdef SNOOP_ARB_RR_EN
    logic        last_owner_q;

    always_comb begin
        win_d = 1'b0;
        if (bus.ooo_req && bus.ppl_req) win_d = ~last_owner_q;
        else if (bus.ppl_req)           win_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)                  last_owner_q <= 1'b1;
        else if (state_q == S_RESP) last_owner_q <= owner_q;
    end
`else
    always_comb begin
        win_d = 1'b0;
        if (!bus.ooo_req && bus.ppl_req) win_d = 1'b1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            owner_q        <= 1'b0;
            cnt_q          <= 8'd0;
            addr_q         <= 32'd0;
            cmd_q          <= 3'd0;
            ooo_gnt_q      <= 1'b0;
            ppl_gnt_q      <= 1'b0;
            snoop_valid_q  <= 1'b0;
            snoop_target_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_code_q    <= 2'd0;
            busy_q         <= 1'b0;
        end else begin
            ooo_gnt_q    <= 1'b0;
            ppl_gnt_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'd0;
            case (state_q)
                S_IDLE: begin
                    if (bus.ooo_req || bus.ppl_req) begin
                        state_q        <= S_SNOOP;
                        owner_q        <= win_d;
                        addr_q         <= win_d ? bus.ppl_addr : bus.ooo_addr;
                        cmd_q          <= win_d ? bus.ppl_cmd  : bus.ooo_cmd;
                        ooo_gnt_q      <= ~win_d;
                        ppl_gnt_q      <= win_d;
                        snoop_valid_q  <= 1'b1;
                        snoop_target_q <= ~win_d;
                        busy_q         <= 1'b1;
                        cnt_q          <= 8'd0;
                    end
                end
                S_SNOOP: begin
                    // ack takes precedence over a timeout on the same cycle
                    if (bus.snoop_ack || cnt_q == CNT_LAST) begin
                        state_q        <= S_RESP;
                        snoop_valid_q  <= 1'b0;
                        snoop_target_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        if (bus.snoop_ack) resp_code_q <= bus.snoop_hit ? 2'd1 : 2'd2;
                        else               resp_code_q <= 2'd3;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ooo_gnt      = ooo_gnt_q;
    assign bus.ppl_gnt      = ppl_gnt_q;
    assign bus.snoop_valid  = snoop_valid_q;
    assign bus.snoop_addr   = addr_q;
    assign bus.snoop_cmd    = cmd_q;
    assign bus.snoop_target = snoop_target_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_code    = resp_code_q;
    assign bus.bus_busy     = busy_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed testbench for snoop_bus_arbiter with TIMEOUT_CYCLES = 16.
module tb_snoop_bus_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    snoop_bus_arbiter_if bus_if();

    snoop_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, bus_if.ooo_gnt, bus_if.ppl_gnt}, 32'd0);
        chk({tag, "_svalid"}, {31'd0, bus_if.snoop_valid}, 32'd0);
        chk({tag, "_saddr"}, bus_if.snoop_addr, 32'd0);
        chk({tag, "_scmd"}, {29'd0, bus_if.snoop_cmd}, 32'd0);
        chk({tag, "_target"}, {31'd0, bus_if.snoop_target}, 32'd0);
        chk({tag, "_resp"}, {29'd0, bus_if.resp_valid, bus_if.resp_code}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus_if.bus_busy}, 32'd0);
    endtask

    initial begin
        int sv_cnt;
        int gnt_cnt;
        int w;
        logic exp_ppl;

        rst = 1'b1;
        bus_if.ooo_req = 0;  bus_if.ppl_req = 0;
        bus_if.ooo_addr = 0; bus_if.ppl_addr = 0;
        bus_if.ooo_cmd = 0;  bus_if.ppl_cmd = 0;
        bus_if.snoop_ack = 0; bus_if.snoop_hit = 0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // single ooo request, hit ack one cycle after grant
        bus_if.ooo_req = 1; bus_if.ooo_addr = 32'h0000_1040; bus_if.ooo_cmd = 3'd2;
        tick();
        chk("hit_ooo_gnt", bus_if.ooo_gnt, 1);
        chk("hit_ppl_gnt", bus_if.ppl_gnt, 0);
        chk("hit_svalid", bus_if.snoop_valid, 1);
        chk("hit_target", bus_if.snoop_target, 1);
        chk("hit_saddr", bus_if.snoop_addr, 32'h0000_1040);
        chk("hit_scmd", bus_if.snoop_cmd, 2);
        chk("hit_busy", bus_if.bus_busy, 1);
        chk("hit_no_resp", bus_if.resp_valid, 0);
        bus_if.ooo_req = 0; bus_if.ooo_addr = 32'hDEAD_BEEF; bus_if.ooo_cmd = 3'd7;
        bus_if.snoop_ack = 1; bus_if.snoop_hit = 1;
        tick();
        chk("hit_resp_valid", bus_if.resp_valid, 1);
        chk("hit_resp_code", bus_if.resp_code, 1);
        chk("hit_svalid_off", bus_if.snoop_valid, 0);
        chk("hit_gnt_once", bus_if.ooo_gnt, 0);
        chk("hit_saddr_held", bus_if.snoop_addr, 32'h0000_1040);
        chk("hit_scmd_held", bus_if.snoop_cmd, 2);
        chk("hit_resp_busy", bus_if.bus_busy, 1);
        bus_if.snoop_ack = 0; bus_if.snoop_hit = 0;
        tick();
        chk("hit_idle_resp", bus_if.resp_valid, 0);
        chk("hit_idle_code", bus_if.resp_code, 0);
        chk("hit_idle_busy", bus_if.bus_busy, 0);

        // stray ack while idle is ignored
        bus_if.snoop_ack = 1; bus_if.snoop_hit = 1;
        tick();
        chk("idle_ack_busy", bus_if.bus_busy, 0);
        chk("idle_ack_resp", bus_if.resp_valid, 0);
        bus_if.snoop_ack = 0; bus_if.snoop_hit = 0;

        // ppl request with no ack: timeout after 16 snoop cycles
        bus_if.ppl_req = 1; bus_if.ppl_addr = 32'hABCD_0000; bus_if.ppl_cmd = 3'd5;
        tick();
        chk("to_ppl_gnt", bus_if.ppl_gnt, 1);
        chk("to_ooo_gnt", bus_if.ooo_gnt, 0);
        chk("to_target", bus_if.snoop_target, 0);
        chk("to_saddr", bus_if.snoop_addr, 32'hABCD_0000);
        bus_if.ppl_req = 0;
        sv_cnt = 1; gnt_cnt = 1; w = 0;
        while (w < 40) begin
            tick();
            w++;
            if (bus_if.ppl_gnt) gnt_cnt++;
            if (!bus_if.snoop_valid) break;
            sv_cnt++;
        end
        chk("to_svalid_cycles", sv_cnt, 16);
        chk("to_gnt_pulses", gnt_cnt, 1);
        chk("to_resp_valid", bus_if.resp_valid, 1);
        chk("to_resp_code", bus_if.resp_code, 3);
        tick();
        chk("to_after_resp", bus_if.resp_valid, 0);
        chk("to_after_busy", bus_if.bus_busy, 0);

        // ack on the same cycle the counter reaches 15
        bus_if.ppl_req = 1; bus_if.ppl_addr = 32'h0000_2000; bus_if.ppl_cmd = 3'd1;
        tick();
        bus_if.ppl_req = 0;
        for (int i = 0; i < 15; i++) tick();
        chk("edge_svalid", bus_if.snoop_valid, 1);
        chk("edge_no_resp", bus_if.resp_valid, 0);
        bus_if.snoop_ack = 1; bus_if.snoop_hit = 0;
        tick();
        chk("edge_resp_valid", bus_if.resp_valid, 1);
        chk("edge_resp_code", bus_if.resp_code, 2);
        bus_if.snoop_ack = 0;
        tick();
        chk("edge_idle", bus_if.bus_busy, 0);

        // reset during the third snoop cycle of a ppl transaction
        bus_if.ppl_req = 1; bus_if.ppl_addr = 32'h0000_3000; bus_if.ppl_cmd = 3'd4;
        tick();
        chk("rst_ppl_gnt", bus_if.ppl_gnt, 1);
        bus_if.ppl_req = 0;
        tick();
        tick();
        chk("rst_third_svalid", bus_if.snoop_valid, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        tick();
        chk("postrst_busy", bus_if.bus_busy, 0);
        chk("postrst_resp", bus_if.resp_valid, 0);

        // both requesters held for four transactions, miss acks
        bus_if.ooo_req = 1; bus_if.ppl_req = 1;
        bus_if.ooo_addr = 32'h0000_4000; bus_if.ppl_addr = 32'h0000_5000;
        bus_if.ooo_cmd = 3'd3; bus_if.ppl_cmd = 3'd6;
        bus_if.snoop_ack = 1; bus_if.snoop_hit = 0;
        for (int t = 0; t < 4; t++) begin
`ifdef SNOOP_ARB_RR_EN
            exp_ppl = (t % 2) == 1;
`else
            exp_ppl = 1'b0;
`endif
            w = 0;
            do begin
                tick();
                w++;
            end while (!(bus_if.ooo_gnt || bus_if.ppl_gnt) && w < 10);
            chk($sformatf("tie%0d_gnt_seen", t), {31'd0, bus_if.ooo_gnt | bus_if.ppl_gnt}, 1);
            chk($sformatf("tie%0d_ppl_gnt", t), bus_if.ppl_gnt, exp_ppl);
            chk($sformatf("tie%0d_ooo_gnt", t), bus_if.ooo_gnt, !exp_ppl);
            chk($sformatf("tie%0d_saddr", t), bus_if.snoop_addr,
                exp_ppl ? 32'h0000_5000 : 32'h0000_4000);
            tick();
            chk($sformatf("tie%0d_resp_valid", t), bus_if.resp_valid, 1);
            chk($sformatf("tie%0d_resp_code", t), bus_if.resp_code, 2);
        end
        bus_if.ooo_req = 0; bus_if.ppl_req = 0; bus_if.snoop_ack = 0;
        tick(); tick();
        chk("final_idle", bus_if.bus_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
